bus_gen_arbiter: RTL and testbench

//  Shared-bus generator/arbiter for bs_gnrtr_n_rbtr.

---
 rtl/bus_gen_arbiter_if.sv | 16 +
 rtl/bus_gen_arbiter.sv | 132 +++++++++++++
 tb/tb_bus_gen_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bus_gen_arbiter_if.sv
// Bundle of per-bus, per-driver FIFO handshake and data lanes between the
// driver FIFO models and the shared-bus arbiter.
interface bus_gen_arbiter_if #(
   parameter int bits    = 1,
   parameter int drvrs   = 4,
   parameter int pckg_sz = 16
);
   logic [bits-1:0][drvrs-1:0]              pndng;
   logic [bits-1:0][drvrs-1:0]              pop;
   logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
   logic [bits-1:0][drvrs-1:0]              push;
   logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

   modport master (input pndng, D_pop, output pop, push, D_push);
   modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_gen_arbiter.sv
// Round-robin shared-bus arbiter: per bus, pop one packet from a pending driver
// FIFO and push it to the FIFO named by its header ID. Macro BUS_BCAST_EN enables broadcast.
module bus_gen_arbiter #(
   parameter int         bits      = 1,
   parameter int         drvrs     = 4,
   parameter int         pckg_sz   = 16,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input logic clk,
   input logic reset,
   bus_gen_arbiter_if.master bus
);
   localparam int IDW = (drvrs > 1) ? $clog2(drvrs) : 1;
`ifdef BUS_BCAST_EN
   localparam bit BCAST = 1'b1;
`else
   localparam bit BCAST = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;
   typedef logic [drvrs-1:0]   lane_t;
   typedef logic [IDW-1:0]     idx_t;
   typedef logic [pckg_sz-1:0] pkt_t;

   state_t   state     [bits];
   state_t   state_nxt [bits];
   idx_t     ptr       [bits];
   idx_t     ptr_nxt   [bits];
   idx_t     src       [bits];
   idx_t     src_nxt   [bits];
   pkt_t     pkt       [bits];
   pkt_t     pkt_nxt   [bits];
   pkt_t     dpush     [bits];
   pkt_t     dpush_nxt [bits];
   logic [IDW:0] win   [bits];
   logic [bits-1:0][drvrs-1:0] pop_q, pop_nxt, push_q, push_nxt;

   // Returns {found, index}; the descending scan leaves the first requester at or after p.
   function automatic logic [IDW:0] pick(input lane_t req, input idx_t p);
      logic [IDW:0] r;
      int j;
      r = '0;
      for (int i = drvrs - 1; i >= 0; i--) begin
         j = int'(p) + i;
         if (j >= drvrs) j = j - drvrs;
         if (req[j]) r = {1'b1, j[IDW-1:0]};
      end
      return r;
   endfunction

   function automatic lane_t dest(input pkt_t pk, input idx_t s);
      logic [7:0] id;
      lane_t m;
      id = pk[pckg_sz-1 -: 8];
      m  = '0;
      if (int'(id) < drvrs) begin
         m[id[IDW-1:0]] = 1'b1;
      end else if (BCAST && (id == broadcast)) begin
         m    = '1;
         m[s] = 1'b0;
      end
      return m;
   endfunction

   always_comb begin
      pop_nxt  = '0;
      push_nxt = '0;
      for (int b = 0; b < bits; b++) begin
         state_nxt[b] = state[b];
         ptr_nxt[b]   = ptr[b];
         src_nxt[b]   = src[b];
         pkt_nxt[b]   = pkt[b];
         dpush_nxt[b] = dpush[b];
         win[b]       = pick(bus.pndng[b], ptr[b]);
         case (state[b])
            IDLE: begin
               if (win[b][IDW]) begin
                  pkt_nxt[b]                  = bus.D_pop[b][win[b][IDW-1:0]];
                  src_nxt[b]                  = win[b][IDW-1:0];
                  pop_nxt[b][win[b][IDW-1:0]] = 1'b1;
                  state_nxt[b]                = POP;
               end
            end
            POP: begin
               // Dropped packets leave D_push showing the last delivered word.
               push_nxt[b] = dest(pkt[b], src[b]);
               if (|push_nxt[b]) dpush_nxt[b] = pkt[b];
               state_nxt[b] = PUSH;
            end
            PUSH: begin
               ptr_nxt[b]   = (int'(src[b]) == drvrs - 1) ? '0 : src[b] + idx_t'(1);
               state_nxt[b] = IDLE;
            end
            default: state_nxt[b] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pop_q  <= '0;
         push_q <= '0;
         for (int b = 0; b < bits; b++) begin
            state[b] <= IDLE;
            ptr[b]   <= '0;
            src[b]   <= '0;
            pkt[b]   <= '0;
            dpush[b] <= '0;
         end
      end else begin
         pop_q  <= pop_nxt;
         push_q <= push_nxt;
         for (int b = 0; b < bits; b++) begin
            state[b] <= state_nxt[b];
            ptr[b]   <= ptr_nxt[b];
            src[b]   <= src_nxt[b];
            pkt[b]   <= pkt_nxt[b];
            dpush[b] <= dpush_nxt[b];
         end
      end
   end

   always_comb begin
      bus.pop  = pop_q;
      bus.push = push_q;
      for (int b = 0; b < bits; b++) begin
         for (int i = 0; i < drvrs; i++) begin
            bus.D_push[b][i] = dpush[b];
         end
      end
   end
endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Directed bench for bus_gen_arbiter with one bus of eight drivers; expectations
// for the broadcast vector follow whether BUS_BCAST_EN is defined.
module tb_bus_gen_arbiter;
   localparam int BITS = 1;
   localparam int DRV  = 8;
   localparam int PSZ  = 16;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   bus_gen_arbiter_if #(.bits(BITS), .drvrs(DRV), .pckg_sz(PSZ)) bus ();

   bus_gen_arbiter #(.bits(BITS), .drvrs(DRV), .pckg_sz(PSZ), .broadcast(8'hFF)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          src;
      logic [15:0] data;
      logic [7:0]  push_exp;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_dpush(input string name, input logic [15:0] exp);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DRV; i++) if (bus.D_push[0][i] !== exp) ok = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: lane0 got %0h expected %0h on every lane", name, bus.D_push[0][0], exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] bc_exp;
      clk       = 1'b0;
      reset     = 1'b1;
      total     = 0;
      bad       = 0;
      bus.pndng = '0;
      bus.D_pop = '0;
`ifdef BUS_BCAST_EN
      bc_exp = 8'b1111_0111;
`else
      bc_exp = 8'h00;
`endif
      vecs[0] = '{src: 2, data: 16'h05AB, push_exp: 8'b0010_0000};
      vecs[1] = '{src: 1, data: 16'h0A00, push_exp: 8'h00};
      vecs[2] = '{src: 3, data: 16'hFF12, push_exp: bc_exp};
      vecs[3] = '{src: 7, data: 16'h0700, push_exp: 8'b1000_0000};
      vecs[4] = '{src: 0, data: 16'h08FF, push_exp: 8'h00};
      vecs[5] = '{src: 5, data: 16'h0034, push_exp: 8'b0000_0001};

      repeat (2) @(negedge clk);
      chk("reset_pop", 32'(bus.pop[0]), 32'h0);
      chk("reset_push", 32'(bus.push[0]), 32'h0);
      chk_dpush("reset_dpush", 16'h0000);
      reset = 1'b0;
      @(negedge clk);

      // Single-source packets: pop at N+1, push at N+2, idle after.
      for (int v = 0; v < 6; v++) begin
         bus.D_pop              = '0;
         bus.D_pop[0][vecs[v].src] = vecs[v].data;
         bus.pndng[0]           = 8'(1) << vecs[v].src;
         cyc();
         chk($sformatf("v%0d_pop", v), 32'(bus.pop[0]), 32'(8'(1) << vecs[v].src));
         chk($sformatf("v%0d_push_early", v), 32'(bus.push[0]), 32'h0);
         bus.pndng[0] = '0;
         cyc();
         chk($sformatf("v%0d_pop_gone", v), 32'(bus.pop[0]), 32'h0);
         chk($sformatf("v%0d_push", v), 32'(bus.push[0]), 32'(vecs[v].push_exp));
         if (vecs[v].push_exp != 8'h00) chk_dpush($sformatf("v%0d_dpush", v), vecs[v].data);
         cyc();
         chk($sformatf("v%0d_idle", v), 32'({bus.pop[0], bus.push[0]}), 32'h0);
      end

      // All drivers pending after reset: grants 0..7 then wrap, one per 3 cycles.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < DRV; i++) bus.D_pop[0][i] = 16'h0000 | 16'(i);
      bus.pndng[0] = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk($sformatf("rr%0d_pop", k), 32'(bus.pop[0]), 32'(8'(1) << (k % DRV)));
         if (k == 9) bus.pndng[0] = '0;
         cyc();
         chk($sformatf("rr%0d_push", k), 32'(bus.push[0]), 32'h01);
         chk_dpush($sformatf("rr%0d_dpush", k), 16'(k % DRV));
         cyc();
      end

      // Reset while in POP: strobes drop at once, pointer returns to 0.
      bus.D_pop          = '0;
      bus.D_pop[0][3]    = 16'h0100;
      bus.pndng[0]       = 8'h08;
      @(posedge clk);
      #1;
      chk("rst_mid_pop_before", 32'(bus.pop[0]), 32'h08);
      #1 reset = 1'b1;
      #1;
      chk("rst_mid_pop", 32'(bus.pop[0]), 32'h0);
      chk("rst_mid_push", 32'(bus.push[0]), 32'h0);
      chk_dpush("rst_mid_dpush", 16'h0000);
      @(negedge clk);
      reset           = 1'b0;
      bus.D_pop[0][0] = 16'h0300;
      bus.pndng[0]    = 8'h09;
      cyc();
      chk("rst_ptr_pop", 32'(bus.pop[0]), 32'h01);
      bus.pndng[0] = '0;
      cyc();
      chk("rst_ptr_push", 32'(bus.push[0]), 32'h08);
      cyc();

      // Driver 0 always pending, driver 4 once: 4 wins before 0 repeats.
      bus.D_pop[0][4] = 16'h0200;
      bus.pndng[0]    = 8'h11;
      cyc();
      chk("fair_pop4", 32'(bus.pop[0]), 32'h10);
      bus.pndng[0] = 8'h01;
      cyc();
      chk("fair_push4", 32'(bus.push[0]), 32'h04);
      chk_dpush("fair_dpush4", 16'h0200);
      cyc();
      cyc();
      chk("fair_pop0", 32'(bus.pop[0]), 32'h01);
      bus.pndng[0] = '0;
      cyc();
      chk("fair_push0", 32'(bus.push[0]), 32'h08);
      chk_dpush("fair_dpush0", 16'h0300);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
